// File: rtl/mk_design_param_fifo_if.sv
// Method-port bundle for mk_design_param_fifo.
// Signal names keep the bit-level EN_*/RDY_*/method__arg style so existing harnesses map
// one-to-one onto the interface members.
//   master: producer/checker side (drives EN_* and arguments, observes RDY_* and values)
//   slave : the FIFO block itself
// W, DEPTH and CW must match the parameters of the mk_design_param_fifo that receives this
// interface.
interface mk_design_param_fifo_if #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 8
) ();
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [W-1:0]    start__sta;
  logic [W-1:0]    start__stb;
  logic            EN_start;
  logic            RDY_start;
  logic [W-1:0]    result__stc;
  logic [W-1:0]    result;
  logic            RDY_result;
  logic [W-1:0]    check__std;
  logic            EN_check;
  logic [W-1:0]    check;
  logic            RDY_check;
  logic [CntW-1:0] count;
  logic [CW-1:0]   mismatch_cnt;

  modport master (
    output start__sta, start__stb, EN_start, result__stc, check__std, EN_check,
    input  RDY_start, result, RDY_result, check, RDY_check, count, mismatch_cnt
  );

  modport slave (
    input  start__sta, start__stb, EN_start, result__stc, check__std, EN_check,
    output RDY_start, result, RDY_result, check, RDY_check, count, mismatch_cnt
  );
endinterface

// File: rtl/mk_design_param_fifo.sv
// Parametrised operand-combining FIFO.
// start  : enqueue (sta op stb) mod 2^W, op = + (MODE 0) or - (MODE 1)
// result : head + stc mod 2^W, 0 when empty (value method)
// check  : head ^ std, 0 when empty; EN_check pops the head and counts nonzero results
//          in a saturating mismatch counter (action-value method)
// Ports:
//   CLK - rising-edge clock
//   RST - asynchronous active-high reset; clears occupancy, pointers and mismatch count
//   bus - mk_design_param_fifo_if slave modport carrying all method signals
// All RDY_* outputs depend on registered state only; stc/std feed result/check
// combinationally.
module mk_design_param_fifo #(
  parameter int unsigned W     = 7,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CW    = 8
) (
  input logic                   CLK,
  input logic                   RST,
  mk_design_param_fifo_if.slave bus
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CW-1:0]   mm_q, mm_d;

  logic            not_full, not_empty;
  logic            push, pop;
  logic [W-1:0]    head;
  logic [W-1:0]    entry;
  logic [W-1:0]    check_val;

  assign not_full  = (count_q < CntW'(DEPTH));
  assign not_empty = (count_q != '0);

  // Accepts are gated by registered RDY, so a full FIFO cannot absorb a push even when a
  // pop happens on the same edge.
  assign push = bus.EN_start & not_full;
  assign pop  = bus.EN_check & not_empty;

  assign head  = mem_q[rd_ptr_q];
  assign entry = (MODE == 0) ? (bus.start__sta + bus.start__stb)
                             : (bus.start__sta - bus.start__stb);
  assign check_val = not_empty ? (head ^ bus.check__std) : '0;

  assign bus.RDY_start    = not_full;
  assign bus.RDY_result   = not_empty;
  assign bus.RDY_check    = not_empty;
  assign bus.result       = not_empty ? (head + bus.result__stc) : '0;
  assign bus.check        = check_val;
  assign bus.count        = count_q;
  assign bus.mismatch_cnt = mm_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mm_d     = mm_q;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (pop && (check_val != '0) && (mm_q != {CW{1'b1}})) begin
      mm_d = mm_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mm_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mm_q     <= mm_d;
    end
  end

  // Storage needs no reset: contents are only visible while count is nonzero.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry;
    end
  end
endmodule
